// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory between an
// instruction-fetch port (0) and a load/store port (1).
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_ack_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  grant_o,
  output logic                  busy_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner;

  // Contention goes to the port not served last; a lone requester always wins.
  assign winner = (p0_req_i && p1_req_i) ? ~last_grant_q : ~p0_req_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          state_d      = S_BUSY;
          cnt_d        = '0;
          grant_d      = winner;
          last_grant_d = winner;
          we_d         = winner ? p1_we_i    : p0_we_i;
          addr_d       = winner ? p1_addr_i  : p0_addr_i;
          wdata_d      = winner ? p1_wdata_i : p0_wdata_i;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = mem_rdata_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_en_o    = (state_q == S_BUSY);
  assign mem_we_o    = (state_q == S_BUSY) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE);
  assign p0_ack_o    = (state_q == S_DONE) && !grant_q;
  assign p1_ack_o    = (state_q == S_DONE) &&  grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (latency 1, 2, 3) share one stimulus
// stream and are checked every cycle against a transaction-timing model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;

  logic        p0_ack[3], p1_ack[3], busy[3], grant[3], mem_en[3], mem_we[3];
  logic [31:0] rdata[3], mem_addr[3], mem_wdata[3];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_ack_o(p0_ack[0]),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_ack_o(p1_ack[0]),
    .rdata_o(rdata[0]), .grant_o(grant[0]), .busy_o(busy[0]), .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata));

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_ack_o(p0_ack[1]),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_ack_o(p1_ack[1]),
    .rdata_o(rdata[1]), .grant_o(grant[1]), .busy_o(busy[1]), .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata));

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_ack_o(p0_ack[2]),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_ack_o(p1_ack[2]),
    .rdata_o(rdata[2]), .grant_o(grant[2]), .busy_o(busy[2]), .mem_en_o(mem_en[2]), .mem_we_o(mem_we[2]),
    .mem_addr_o(mem_addr[2]), .mem_wdata_o(mem_wdata[2]), .mem_rdata_i(mem_rdata));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: an access is described by its accept cycle s; memory is enabled in
  // cycles s+1..s+L and the ack lands in cycle s+L+1.
  int          cyc = 0;
  bit          ready = 1'b0;
  bit          m_act[3], m_win[3], m_we[3], m_grant[3], m_last[3];
  int          m_s[3];
  logic [31:0] m_addr[3], m_wdata[3], m_rdata[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_act[k] = 0; m_grant[k] = 0; m_last[k] = 1; m_we[k] = 0;
        m_addr[k] = '0; m_wdata[k] = '0; m_rdata[k] = '0;
      end else if (m_act[k] && cyc == m_s[k] + k + 2) begin
        m_act[k] = 0;
      end else if (m_act[k]) begin
        if (cyc == m_s[k] + k + 1 && !m_we[k]) m_rdata[k] = mem_rdata;
      end else if (p0_req || p1_req) begin
        m_win[k]   = (p0_req && p1_req) ? !m_last[k] : p1_req;
        m_last[k]  = m_win[k];
        m_grant[k] = m_win[k];
        m_we[k]    = m_win[k] ? p1_we : p0_we;
        m_addr[k]  = m_win[k] ? p1_addr : p0_addr;
        m_wdata[k] = m_win[k] ? p1_wdata : p0_wdata;
        m_act[k]   = 1;
        m_s[k]     = cyc;
      end
    end
    if (!rst_n) ready = 1'b1;
    cyc++;
  end

  bit e_en, e_dn;
  always @(negedge clk) begin
    if (ready) begin
      for (int k = 0; k < 3; k++) begin
        e_en = m_act[k] && cyc >= m_s[k] + 1 && cyc <= m_s[k] + k + 1;
        e_dn = m_act[k] && cyc == m_s[k] + k + 2;
        chk($sformatf("L%0d.busy", k + 1), 32'(busy[k]), 32'(m_act[k]));
        chk($sformatf("L%0d.mem_en", k + 1), 32'(mem_en[k]), 32'(e_en));
        chk($sformatf("L%0d.mem_we", k + 1), 32'(mem_we[k]), 32'(e_en && m_we[k]));
        chk($sformatf("L%0d.p0_ack", k + 1), 32'(p0_ack[k]), 32'(e_dn && !m_win[k]));
        chk($sformatf("L%0d.p1_ack", k + 1), 32'(p1_ack[k]), 32'(e_dn && m_win[k]));
        chk($sformatf("L%0d.grant", k + 1), 32'(grant[k]), 32'(m_grant[k]));
        chk($sformatf("L%0d.rdata", k + 1), rdata[k], m_rdata[k]);
        chk($sformatf("L%0d.mem_addr", k + 1), mem_addr[k], m_addr[k]);
        chk($sformatf("L%0d.mem_wdata", k + 1), mem_wdata[k], m_wdata[k]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle(input int n);
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    tick(n);
  endtask

  task automatic pattern(input bit r0, input bit w0, input logic [31:0] a0,
                         input bit r1, input bit w1, input logic [31:0] a1, input int n);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = a0 ^ 32'h5555_AAAA;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = a1 ^ 32'h0F0F_3C3C;
    repeat (n) begin
      mem_rdata = $urandom;
      tick(1);
    end
    idle(7);
  endtask

  initial begin
    rst_n = 0; p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; mem_rdata = '0;
    tick(3);
    chk("reset.grant", 32'(grant[1]), 32'd0);
    chk("reset.busy", 32'(busy[2]), 32'd0);
    rst_n = 1;
    idle(2);

    // Single read, latency 2
    mem_rdata = 32'hDEAD_BEEF; p0_addr = 32'h40; p0_req = 1;
    tick(1);
    chk("t1.en_c1", 32'(mem_en[1]), 32'd1);
    chk("t1.addr_c1", mem_addr[1], 32'h40);
    tick(1);
    chk("t1.en_c2", 32'(mem_en[1]), 32'd1);
    tick(1);
    chk("t1.ack_c3", 32'(p0_ack[1]), 32'd1);
    chk("t1.rdata_c3", rdata[1], 32'hDEAD_BEEF);
    idle(6);

    // Both ports requesting straight out of reset, latency 2
    rst_n = 0; mem_rdata = 32'h0BAD_F00D;
    p0_addr = 32'h100; p1_addr = 32'h200; p0_req = 1; p1_req = 1;
    tick(1);
    rst_n = 1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (i % 4 == 1) chk("t2.grant", 32'(grant[1]), 32'((i / 4) % 2));
      if (i % 4 == 3) begin
        chk("t2.p0_ack", 32'(p0_ack[1]), 32'((i / 4) % 2 == 0));
        chk("t2.p1_ack", 32'(p1_ack[1]), 32'((i / 4) % 2 == 1));
      end
    end
    idle(6);

    // Port 1 write, latency 1: rdata keeps the last read value
    mem_rdata = 32'hCAFE_0001;
    p1_we = 1; p1_addr = 32'h10; p1_wdata = 32'h1234_5678; p1_req = 1;
    tick(1);
    chk("t3.we_c1", 32'(mem_we[0]), 32'd1);
    chk("t3.wdata_c1", mem_wdata[0], 32'h1234_5678);
    chk("t3.addr_c1", mem_addr[0], 32'h10);
    tick(1);
    chk("t3.ack_c2", 32'(p1_ack[0]), 32'd1);
    chk("t3.rdata_c2", rdata[0], 32'h0BAD_F00D);
    idle(6);

    // Reset during the second busy cycle of a latency-3 access
    p0_addr = 32'h300; p0_req = 1;
    tick(2);
    rst_n = 0;
    tick(1);
    chk("t4.busy", 32'(busy[2]), 32'd0);
    chk("t4.en", 32'(mem_en[2]), 32'd0);
    chk("t4.acks", 32'(p0_ack[2] | p1_ack[2]), 32'd0);
    rst_n = 1; p1_addr = 32'h310; p1_req = 1;
    tick(1);
    chk("t4.grant", 32'(grant[2]), 32'd0);
    chk("t4.addr", mem_addr[2], 32'h300);
    idle(8);

    // Requester address changes mid-access, latency 2
    mem_rdata = 32'h7777_0000; p0_addr = 32'h40; p0_req = 1;
    tick(1);
    p0_addr = 32'h80;
    chk("t5.addr_c1", mem_addr[1], 32'h40);
    tick(1);
    chk("t5.addr_c2", mem_addr[1], 32'h40);
    tick(1);
    chk("t5.addr_c3", mem_addr[1], 32'h40);
    chk("t5.ack_c3", 32'(p0_ack[1]), 32'd1);
    idle(6);

    // Port 0 alone back to back, latency 1: an ack every third cycle
    p0_addr = 32'h44; p0_req = 1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("t6.p0_ack", 32'(p0_ack[0]), 32'(i % 3 == 2));
      chk("t6.p1_ack", 32'(p1_ack[0]), 32'd0);
    end
    idle(6);

    pattern(1, 1, 32'h500, 1, 0, 32'h600, 10);
    pattern(0, 0, 32'h000, 1, 1, 32'h700, 5);
    pattern(1, 0, 32'h800, 1, 1, 32'h900, 14);
    pattern(1, 1, 32'hA00, 0, 0, 32'h000, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
